video_frame_buffer_scheduler: RTL and testbench
===============================================

Name: video_frame_buffer_scheduler

Overview:
- Sequences DDR writes of the preprocessed video stream into a rotating set of frame buffers.
- Sits after the video analyze/preprocess stage and in front of the DDR write port.
- Uses the analyze outputs (coordinates, frame end, resolution change) and the line-FIFO fill level to issue burst write requests.
- Tells the HDMI read side which frame is the latest complete one, and never writes into the frame the reader has locked.

Parameters:
FRAME_BASE_ADDR, 32'h0000_0000, byte address of frame buffer 0
FRAME_STRIDE, 32'h0080_0000, byte distance between consecutive frame buffers
BUF_NUM, 3, number of frame buffers (2..4)
BURST_LEN, 64, maximum beats per write burst (1..255)
BEAT_BYTES, 4, bytes per beat (one pixel per beat)
FIFO_DEPTH, 512, depth of the upstream pixel FIFO in beats

Ports:
i_pclk  in  1  pixel clock; all logic rises on it
i_rst  in  1  synchronous reset, active-high
i_video_vde  in  1  pixel valid from analyze stage
i_video_x  in  12  current pixel X
i_video_y  in  12  current pixel Y
i_video_end  in  1  frame end; rising edge marks end of frame
i_video_change  in  1  resolution changed, level high
i_wr_fifo_cnt  in  10  beats currently held in pixel FIFO
o_wr_req  out  1  burst request
o_wr_addr  out  32  burst start byte address
o_wr_len  out  8  burst length in beats
i_wr_ack  in  1  1-cycle pulse: request accepted
i_wr_done  in  1  1-cycle pulse: burst data fully consumed
o_wr_frame_idx  out  2  buffer currently being written
o_rd_frame_idx  out  2  latest complete buffer for the reader
o_frame_valid  out  1  o_rd_frame_idx holds a complete frame
i_rd_frame_lock  in  1  reader is using a buffer; sampled on rising edge
o_overflow  out  1  sticky FIFO-overflow flag

Behaviour:
- Reset values (i_rst high at a clock edge):
  - State = IDLE.
  - o_wr_req = 0, o_wr_addr = FRAME_BASE_ADDR, o_wr_len = 0.
  - o_wr_frame_idx = 0, o_rd_frame_idx = 0, o_frame_valid = 0, o_overflow = 0.
  - Byte offset = 0, pending_eof = 0, reader_idx = 0.
- Reset mid-burst drops the burst immediately. Downstream is reset by the same signal.
- States:
  - IDLE → WAIT_SOF one cycle after reset release.
  - WAIT_SOF: wait for i_video_vde=1 with x=0, y=0.
    - On that cycle: offset := 0, o_overflow := 0, go to ACTIVE.
  - ACTIVE: issue a burst when i_wr_fifo_cnt ≥ BURST_LEN (len = BURST_LEN), or when pending_eof=1 and i_wr_fifo_cnt > 0 (len = i_wr_fifo_cnt).
    - On the next cycle: o_wr_req = 1, o_wr_addr = FRAME_BASE_ADDR + o_wr_frame_idx*FRAME_STRIDE + offset, o_wr_len = len. Go to REQ.
    - If pending_eof=1 and i_wr_fifo_cnt = 0, go to FRAME_DONE.
  - REQ: o_wr_req, o_wr_addr and o_wr_len stay stable until i_wr_ack. o_wr_req drops the cycle after ack. Go to BURST.
  - BURST: wait for i_wr_done, then offset += o_wr_len*BEAT_BYTES (32-bit, no saturation) and return to ACTIVE.
    - An i_wr_done coincident with i_wr_ack counts.
  - FRAME_DONE (one cycle):
    - o_rd_frame_idx := o_wr_frame_idx; o_frame_valid := 1.
    - Next write index n = (o_wr_frame_idx+1) mod BUF_NUM. If i_rd_frame_lock=1 and n = reader_idx, then n = (n+1) mod BUF_NUM.
    - o_wr_frame_idx := n; clear pending_eof; go to WAIT_SOF.
- pending_eof: set on a rising edge of i_video_end (registered edge detect) in ACTIVE, REQ or BURST. Ignored in other states.
- reader_idx: on a rising edge of i_rd_frame_lock, reader_idx := o_rd_frame_idx. It is held while the lock is high. When the lock is low, it does not block rotation.
- i_video_change=1:
  - In WAIT_SOF or ACTIVE: go to WAIT_SOF next cycle; o_frame_valid := 0; pending_eof := 0; o_wr_frame_idx unchanged.
  - In REQ or BURST: finish the handshake through i_wr_done, then do the same abort instead of returning to ACTIVE.
- Overflow: i_wr_fifo_cnt ≥ FIFO_DEPTH-1 in any state except IDLE sets o_overflow. It stays set until the next SOF.
- Simultaneous burst condition and pending_eof: the full-burst rule takes priority; flush bursts follow.
- At most one outstanding request.

Test Plan:
- 640x2 frame, FIFO fills to 64 repeatedly → 20 bursts, len=64, addresses 0, 256, 512 … 4864, o_wr_frame_idx=0. After the end edge: o_rd_frame_idx=0, o_frame_valid=1, o_wr_frame_idx=1.
- Frame of 100 pixels, end edge with fifo_cnt=36 after one 64-burst → second burst len=36 at address FRAME_BASE+64*4 of the current buffer. Then FRAME_DONE.
- 3 frames, no lock → o_wr_frame_idx sequence 0,1,2,0. Address of buffer 2 first burst = 32'h0100_0000.
- Reader locks when o_rd_frame_idx=1, frame 2 completes → next write index skips 1: 2→0, then 0→2 (skipping 1) while the lock is held.
- i_video_change asserted during BURST → o_wr_req stays low after i_wr_done, o_frame_valid=0, next burst only after a new x=0/y=0 SOF, address offset 0.
- i_wr_fifo_cnt=511 while ACTIVE → o_overflow=1 next cycle, held through FRAME_DONE, cleared at the next SOF. i_rst pulse mid-REQ → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/video_frame_buffer_scheduler.sv
// -----------------------------------------------------------------------------
// video_frame_buffer_scheduler
//
// Turns the preprocessed pixel stream into DDR burst write requests that fill
// a rotating set of frame buffers. It tells the HDMI reader which buffer holds
// the latest complete frame, and it never rotates into the buffer the reader
// has locked.
//
// Ports
//   i_pclk            pixel clock; all state changes on its rising edge
//   i_rst             synchronous reset, active-high
//   i_video_vde       pixel valid from the analyze stage
//   i_video_x/y       current pixel coordinates (x=0,y=0 with vde marks SOF)
//   i_video_end       frame end; its rising edge requests the end-of-frame flush
//   i_video_change    resolution changed (level); aborts the current frame
//   i_wr_fifo_cnt     beats currently held in the upstream pixel FIFO
//   o_wr_req          burst request, held until i_wr_ack
//   o_wr_addr         burst start byte address
//   o_wr_len          burst length in beats
//   i_wr_ack          1-cycle pulse: request accepted
//   i_wr_done         1-cycle pulse: burst data fully consumed
//   o_wr_frame_idx    buffer currently being written
//   o_rd_frame_idx    latest complete buffer for the reader
//   o_frame_valid     o_rd_frame_idx holds a complete frame
//   i_rd_frame_lock   reader holds a buffer; its rising edge captures the index
//   o_overflow        sticky FIFO-overflow flag, cleared at the next SOF
// -----------------------------------------------------------------------------
module video_frame_buffer_scheduler #(
    parameter logic [31:0] FRAME_BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] FRAME_STRIDE    = 32'h0080_0000,
    parameter int          BUF_NUM         = 3,
    parameter int          BURST_LEN       = 64,
    parameter int          BEAT_BYTES      = 4,
    parameter int          FIFO_DEPTH      = 512
) (
    input  logic        i_pclk,
    input  logic        i_rst,
    input  logic        i_video_vde,
    input  logic [11:0] i_video_x,
    input  logic [11:0] i_video_y,
    input  logic        i_video_end,
    input  logic        i_video_change,
    input  logic [9:0]  i_wr_fifo_cnt,
    output logic        o_wr_req,
    output logic [31:0] o_wr_addr,
    output logic [7:0]  o_wr_len,
    input  logic        i_wr_ack,
    input  logic        i_wr_done,
    output logic [1:0]  o_wr_frame_idx,
    output logic [1:0]  o_rd_frame_idx,
    output logic        o_frame_valid,
    input  logic        i_rd_frame_lock,
    output logic        o_overflow
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_ACTIVE,
        ST_REQ,
        ST_BURST,
        ST_FRAME_DONE
    } state_t;

    localparam logic [9:0]  BURST_LEN_CNT   = 10'(BURST_LEN);
    localparam logic [7:0]  BURST_LEN_BEATS = 8'(BURST_LEN);
    localparam logic [10:0] OVERFLOW_LEVEL  = 11'(FIFO_DEPTH - 1);
    localparam logic [31:0] BEAT_BYTES_W    = 32'(BEAT_BYTES);
    localparam logic [1:0]  LAST_IDX        = 2'(BUF_NUM - 1);

    // Base address of every possible buffer as a constant table, so the
    // request address is a lookup plus the running offset (no multiplier).
    logic [31:0] buf_base [0:3];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_buf_base
            assign buf_base[gi] = FRAME_BASE_ADDR + 32'(gi) * FRAME_STRIDE;
        end
    endgenerate

    state_t      state_reg,        state_next;
    logic        wr_req_reg,       wr_req_next;
    logic [31:0] wr_addr_reg,      wr_addr_next;
    logic [7:0]  wr_len_reg,       wr_len_next;
    logic [1:0]  wr_frame_idx_reg, wr_frame_idx_next;
    logic [1:0]  rd_frame_idx_reg, rd_frame_idx_next;
    logic        frame_valid_reg,  frame_valid_next;
    logic        overflow_reg,     overflow_next;
    logic [31:0] offset_reg,       offset_next;
    logic        pending_eof_reg,  pending_eof_next;
    logic [1:0]  reader_idx_reg,   reader_idx_next;
    logic        abort_reg,        abort_next;
    logic        end_d_reg,        end_d_next;
    logic        lock_d_reg,       lock_d_next;

    logic        sof;
    logic        end_rise;
    logic        lock_rise;
    logic        burst_full;
    logic        burst_flush;
    logic        burst_complete;
    logic [7:0]  issue_len;
    logic [31:0] burst_bytes;
    logic [1:0]  next_idx_a;
    logic [1:0]  next_idx_b;
    logic        rotate_blocked;

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state_reg        <= ST_IDLE;
            wr_req_reg       <= 1'b0;
            wr_addr_reg      <= FRAME_BASE_ADDR;
            wr_len_reg       <= 8'd0;
            wr_frame_idx_reg <= 2'd0;
            rd_frame_idx_reg <= 2'd0;
            frame_valid_reg  <= 1'b0;
            overflow_reg     <= 1'b0;
            offset_reg       <= 32'd0;
            pending_eof_reg  <= 1'b0;
            reader_idx_reg   <= 2'd0;
            abort_reg        <= 1'b0;
            end_d_reg        <= 1'b0;
            lock_d_reg       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            wr_req_reg       <= wr_req_next;
            wr_addr_reg      <= wr_addr_next;
            wr_len_reg       <= wr_len_next;
            wr_frame_idx_reg <= wr_frame_idx_next;
            rd_frame_idx_reg <= rd_frame_idx_next;
            frame_valid_reg  <= frame_valid_next;
            overflow_reg     <= overflow_next;
            offset_reg       <= offset_next;
            pending_eof_reg  <= pending_eof_next;
            reader_idx_reg   <= reader_idx_next;
            abort_reg        <= abort_next;
            end_d_reg        <= end_d_next;
            lock_d_reg       <= lock_d_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        wr_req_next       = wr_req_reg;
        wr_addr_next      = wr_addr_reg;
        wr_len_next       = wr_len_reg;
        wr_frame_idx_next = wr_frame_idx_reg;
        rd_frame_idx_next = rd_frame_idx_reg;
        frame_valid_next  = frame_valid_reg;
        overflow_next     = overflow_reg;
        offset_next       = offset_reg;
        pending_eof_next  = pending_eof_reg;
        reader_idx_next   = reader_idx_reg;
        abort_next        = abort_reg;
        end_d_next        = i_video_end;
        lock_d_next       = i_rd_frame_lock;

        sof         = i_video_vde && (i_video_x == 12'd0) && (i_video_y == 12'd0);
        end_rise    = i_video_end && !end_d_reg;
        lock_rise   = i_rd_frame_lock && !lock_d_reg;
        burst_full  = (i_wr_fifo_cnt >= BURST_LEN_CNT);
        burst_flush = pending_eof_reg && (i_wr_fifo_cnt != 10'd0);
        // A flush is only taken when the FIFO is below a full burst, so the
        // residual count always fits in the 8-bit length.
        issue_len   = burst_full ? BURST_LEN_BEATS : i_wr_fifo_cnt[7:0];
        burst_bytes = {24'd0, wr_len_reg} * BEAT_BYTES_W;

        // A done pulse landing on the ack cycle closes the burst right away.
        burst_complete = i_wr_done &&
                         (((state_reg == ST_REQ) && i_wr_ack) || (state_reg == ST_BURST));

        next_idx_a     = (wr_frame_idx_reg == LAST_IDX) ? 2'd0 : wr_frame_idx_reg + 2'd1;
        next_idx_b     = (next_idx_a == LAST_IDX) ? 2'd0 : next_idx_a + 2'd1;
        rotate_blocked = i_rd_frame_lock && (next_idx_a == reader_idx_reg);

        if (lock_rise) begin
            reader_idx_next = rd_frame_idx_reg;
        end

        case (state_reg)
            ST_IDLE: begin
                state_next = ST_WAIT_SOF;
            end

            ST_WAIT_SOF: begin
                if (i_video_change) begin
                    frame_valid_next = 1'b0;
                    pending_eof_next = 1'b0;
                end else if (sof) begin
                    offset_next   = 32'd0;
                    overflow_next = 1'b0;
                    state_next    = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                if (end_rise) begin
                    pending_eof_next = 1'b1;
                end
                if (i_video_change) begin
                    frame_valid_next = 1'b0;
                    pending_eof_next = 1'b0;
                    state_next       = ST_WAIT_SOF;
                end else if (burst_full || burst_flush) begin
                    wr_req_next  = 1'b1;
                    wr_addr_next = buf_base[wr_frame_idx_reg] + offset_reg;
                    wr_len_next  = issue_len;
                    state_next   = ST_REQ;
                end else if (pending_eof_reg) begin
                    state_next = ST_FRAME_DONE;
                end
            end

            ST_REQ: begin
                if (end_rise) begin
                    pending_eof_next = 1'b1;
                end
                if (i_video_change) begin
                    abort_next = 1'b1;
                end
                if (i_wr_ack) begin
                    wr_req_next = 1'b0;
                    state_next  = ST_BURST;
                end
            end

            ST_BURST: begin
                if (end_rise) begin
                    pending_eof_next = 1'b1;
                end
                if (i_video_change) begin
                    abort_next = 1'b1;
                end
            end

            ST_FRAME_DONE: begin
                rd_frame_idx_next = wr_frame_idx_reg;
                frame_valid_next  = 1'b1;
                wr_frame_idx_next = rotate_blocked ? next_idx_b : next_idx_a;
                pending_eof_next  = 1'b0;
                state_next        = ST_WAIT_SOF;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A resolution change seen at any point of the handshake turns the
        // return to ACTIVE into the same abort used outside a burst.
        if (burst_complete) begin
            offset_next = offset_reg + burst_bytes;
            abort_next  = 1'b0;
            if (abort_reg || i_video_change) begin
                frame_valid_next = 1'b0;
                pending_eof_next = 1'b0;
                state_next       = ST_WAIT_SOF;
            end else begin
                state_next = ST_ACTIVE;
            end
        end

        // Setting wins over the SOF clear when both happen together.
        if ((state_reg != ST_IDLE) && ({1'b0, i_wr_fifo_cnt} >= OVERFLOW_LEVEL)) begin
            overflow_next = 1'b1;
        end
    end

    assign o_wr_req       = wr_req_reg;
    assign o_wr_addr      = wr_addr_reg;
    assign o_wr_len       = wr_len_reg;
    assign o_wr_frame_idx = wr_frame_idx_reg;
    assign o_rd_frame_idx = rd_frame_idx_reg;
    assign o_frame_valid  = frame_valid_reg;
    assign o_overflow     = overflow_reg;

endmodule

// File: tb/tb_video_frame_buffer_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for video_frame_buffer_scheduler. The bench plays the analyze stage,
// the pixel FIFO level and the DDR write port. A frame-level model (buffer
// rotation, expected burst list, valid/overflow flags) is checked by one
// compare process every cycle; literal checks pin key values of the model.
// -----------------------------------------------------------------------------
module tb_video_frame_buffer_scheduler;

    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] STRIDE = 32'h0080_0000;
    localparam int          NBUF   = 3;

    logic        pclk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_video_vde = 1'b0;
    logic [11:0] i_video_x = 12'd0;
    logic [11:0] i_video_y = 12'd0;
    logic        i_video_end = 1'b0;
    logic        i_video_change = 1'b0;
    logic [9:0]  i_wr_fifo_cnt = 10'd0;
    logic        i_wr_ack = 1'b0;
    logic        i_wr_done = 1'b0;
    logic        i_rd_frame_lock = 1'b0;
    logic        o_wr_req;
    logic [31:0] o_wr_addr;
    logic [7:0]  o_wr_len;
    logic [1:0]  o_wr_frame_idx;
    logic [1:0]  o_rd_frame_idx;
    logic        o_frame_valid;
    logic        o_overflow;

    video_frame_buffer_scheduler dut (
        .i_pclk          (pclk),
        .i_rst           (i_rst),
        .i_video_vde     (i_video_vde),
        .i_video_x       (i_video_x),
        .i_video_y       (i_video_y),
        .i_video_end     (i_video_end),
        .i_video_change  (i_video_change),
        .i_wr_fifo_cnt   (i_wr_fifo_cnt),
        .o_wr_req        (o_wr_req),
        .o_wr_addr       (o_wr_addr),
        .o_wr_len        (o_wr_len),
        .i_wr_ack        (i_wr_ack),
        .i_wr_done       (i_wr_done),
        .o_wr_frame_idx  (o_wr_frame_idx),
        .o_rd_frame_idx  (o_rd_frame_idx),
        .o_frame_valid   (o_frame_valid),
        .i_rd_frame_lock (i_rd_frame_lock),
        .o_overflow      (o_overflow)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    burst_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // Frame-level model state.
    int m_wr = 0;
    int m_rd = 0;
    int m_reader = 0;
    bit m_valid = 1'b0;
    bit m_ovf = 1'b0;
    bit m_lock = 1'b0;
    bit chk_en = 1'b0;

    logic        prev_req = 1'b0;
    logic [31:0] cur_addr = 32'd0;
    logic [7:0]  cur_len = 8'd0;
    logic [31:0] last_req_addr = 32'd0;
    logic [7:0]  last_req_len = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Next write buffer after a completed frame, from the rotation rule.
    function automatic int next_idx(input int cur);
        int n;
        n = (cur + 1) % NBUF;
        if (m_lock && (n == m_reader)) n = (n + 1) % NBUF;
        return n;
    endfunction

    // Compare process: new requests against the expected burst list, held
    // requests against the same entry, and frame status against the model.
    always @(negedge pclk) begin
        if (o_wr_req && !prev_req) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_req: got addr=0x%08h len=%0d expected no request", o_wr_addr, o_wr_len);
            end else begin
                burst_t e;
                e = exp_q.pop_front();
                cur_addr = e.addr;
                cur_len  = e.len;
                chk("burst_addr", o_wr_addr, e.addr);
                chk("burst_len", 32'(o_wr_len), 32'(e.len));
            end
            last_req_addr = o_wr_addr;
            last_req_len  = o_wr_len;
            $display("[TB] burst request addr=0x%08h len=%0d frame=%0d", o_wr_addr, o_wr_len, o_wr_frame_idx);
        end else if (o_wr_req && prev_req) begin
            chk("req_hold_addr", o_wr_addr, cur_addr);
            chk("req_hold_len", 32'(o_wr_len), 32'(cur_len));
        end
        prev_req = o_wr_req;
        if (chk_en) begin
            chk("wr_frame_idx", 32'(o_wr_frame_idx), 32'(m_wr));
            chk("rd_frame_idx", 32'(o_rd_frame_idx), 32'(m_rd));
            chk("frame_valid", 32'(o_frame_valid), 32'(m_valid));
            chk("overflow", 32'(o_overflow), 32'(m_ovf));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic send_sof();
        i_video_vde = 1'b1;
        i_video_x   = 12'd0;
        i_video_y   = 12'd0;
        tick();
        m_ovf = 1'b0;
        i_video_vde = 1'b0;
        i_video_x   = 12'd5;
    endtask

    // Present cnt_val beats, expect one request, then ack and complete it.
    task automatic do_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [9:0] cnt_val, input bit coincide);
        bit got;
        got = 1'b0;
        exp_q.push_back('{addr, len});
        i_wr_fifo_cnt = cnt_val;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cnt_val >= 10'd511) m_ovf = 1'b1;
            if (o_wr_req) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: got no request expected addr=0x%08h len=%0d", addr, len);
            i_wr_fifo_cnt = 10'd0;
            return;
        end
        i_wr_fifo_cnt = 10'd0;
        i_wr_ack = 1'b1;
        if (coincide) i_wr_done = 1'b1;
        tick();
        i_wr_ack  = 1'b0;
        i_wr_done = 1'b0;
        chk("req_drop_after_ack", 32'(o_wr_req), 32'd0);
        if (!coincide) begin
            tick();
            i_wr_done = 1'b1;
            tick();
            i_wr_done = 1'b0;
        end
    endtask

    // End edge, optional flush burst, then the frame-done rotation.
    task automatic finish_frame(input logic [31:0] addr, input int rem);
        chk_en = 1'b0;
        i_video_end   = 1'b1;
        i_wr_fifo_cnt = 10'(rem);
        tick();
        i_video_end = 1'b0;
        if (rem > 0) do_burst(addr, 8'(rem), 10'(rem), 1'b0);
        repeat (3) tick();
        m_rd    = m_wr;
        m_valid = 1'b1;
        m_wr    = next_idx(m_wr);
        chk_en  = 1'b1;
    endtask

    task automatic run_frame(input int npix, input logic [9:0] first_cnt, input bit coincide);
        int full;
        int rem;
        logic [31:0] base;
        full = npix / 64;
        rem  = npix % 64;
        base = BASE + 32'(m_wr) * STRIDE;
        send_sof();
        for (int k = 0; k < full; k++) begin
            do_burst(base + 32'(k * 256), 8'd64, (k == 0) ? first_cnt : 10'd64, coincide && (k == 0));
        end
        finish_frame(base + 32'(full * 256), rem);
        $display("[TB] frame of %0d pixels done: wr=%0d rd=%0d valid=%0d", npix, o_wr_frame_idx, o_rd_frame_idx, o_frame_valid);
    endtask

    initial begin
        // Reset values.
        repeat (3) tick();
        chk("rst_wr_req", 32'(o_wr_req), 32'd0);
        chk("rst_wr_addr", o_wr_addr, 32'h0000_0000);
        chk("rst_wr_len", 32'(o_wr_len), 32'd0);
        chk("rst_wr_frame_idx", 32'(o_wr_frame_idx), 32'd0);
        chk("rst_rd_frame_idx", 32'(o_rd_frame_idx), 32'd0);
        chk("rst_frame_valid", 32'(o_frame_valid), 32'd0);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
        i_rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) tick();

        // 640x2 frame: twenty full bursts into buffer 0.
        run_frame(1280, 10'd64, 1'b0);
        chk("a_last_addr", last_req_addr, 32'h0000_1300);
        chk("a_rd_idx", 32'(o_rd_frame_idx), 32'd0);
        chk("a_valid", 32'(o_frame_valid), 32'd1);
        chk("a_wr_idx", 32'(o_wr_frame_idx), 32'd1);

        // 100-pixel frame: one full burst (ack and done together) and a flush of 36.
        run_frame(100, 10'd64, 1'b1);
        chk("b_flush_addr", last_req_addr, 32'h0080_0100);
        chk("b_flush_len", 32'(last_req_len), 32'd36);
        chk("b_wr_idx", 32'(o_wr_frame_idx), 32'd2);

        // Reader locks buffer 1.
        i_rd_frame_lock = 1'b1;
        m_lock   = 1'b1;
        m_reader = m_rd;
        repeat (2) tick();

        run_frame(64, 10'd64, 1'b0);
        chk("c_first_addr", last_req_addr, 32'h0100_0000);
        chk("c_wr_idx", 32'(o_wr_frame_idx), 32'd0);

        run_frame(64, 10'd64, 1'b0);
        chk("d_wr_idx_skip", 32'(o_wr_frame_idx), 32'd2);
        chk("d_rd_idx", 32'(o_rd_frame_idx), 32'd0);

        // Lock released: rotation is no longer blocked.
        i_rd_frame_lock = 1'b0;
        m_lock = 1'b0;
        tick();
        run_frame(64, 10'd64, 1'b0);
        run_frame(64, 10'd64, 1'b0);
        chk("f_wr_idx", 32'(o_wr_frame_idx), 32'd1);

        // Resolution change during BURST aborts the frame.
        send_sof();
        exp_q.push_back('{BASE + 32'(m_wr) * STRIDE, 8'd64});
        i_wr_fifo_cnt = 10'd64;
        for (int i = 0; i < 20 && !o_wr_req; i++) tick();
        i_wr_fifo_cnt = 10'd0;
        i_wr_ack = 1'b1;
        tick();
        i_wr_ack = 1'b0;
        chk_en = 1'b0;
        i_video_change = 1'b1;
        tick();
        i_wr_done = 1'b1;
        tick();
        i_wr_done = 1'b0;
        tick();
        i_video_change = 1'b0;
        m_valid = 1'b0;
        chk("g_valid_cleared", 32'(o_frame_valid), 32'd0);
        chk("g_wr_idx_kept", 32'(o_wr_frame_idx), 32'd1);
        chk_en = 1'b1;
        i_wr_fifo_cnt = 10'd64;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("g_no_req_before_sof", 32'(o_wr_req), 32'd0);
        end
        i_wr_fifo_cnt = 10'd0;
        tick();
        run_frame(64, 10'd64, 1'b0);
        chk("g_restart_addr", last_req_addr, 32'h0080_0000);

        // Overflow: FIFO level 511 while ACTIVE.
        send_sof();
        do_burst(BASE + 32'(m_wr) * STRIDE, 8'd64, 10'd511, 1'b0);
        chk("h_overflow_set", 32'(o_overflow), 32'd1);
        finish_frame(BASE + 32'(m_wr) * STRIDE + 32'd256, 0);
        chk("h_overflow_held", 32'(o_overflow), 32'd1);

        // Next SOF clears overflow; reset lands in the middle of REQ.
        send_sof();
        chk("i_overflow_cleared", 32'(o_overflow), 32'd0);
        do_burst(BASE + 32'(m_wr) * STRIDE, 8'd64, 10'd64, 1'b0);
        exp_q.push_back('{BASE + 32'(m_wr) * STRIDE + 32'd256, 8'd64});
        i_wr_fifo_cnt = 10'd64;
        for (int i = 0; i < 20 && !o_wr_req; i++) tick();
        chk("i_in_req", 32'(o_wr_req), 32'd1);
        chk_en = 1'b0;
        i_rst = 1'b1;
        i_wr_fifo_cnt = 10'd0;
        tick();
        chk("i_rst_wr_req", 32'(o_wr_req), 32'd0);
        chk("i_rst_wr_addr", o_wr_addr, 32'h0000_0000);
        chk("i_rst_wr_len", 32'(o_wr_len), 32'd0);
        chk("i_rst_wr_idx", 32'(o_wr_frame_idx), 32'd0);
        chk("i_rst_rd_idx", 32'(o_rd_frame_idx), 32'd0);
        chk("i_rst_valid", 32'(o_frame_valid), 32'd0);
        m_wr = 0;
        m_rd = 0;
        m_valid = 1'b0;
        m_ovf = 1'b0;
        chk_en = 1'b1;
        i_rst = 1'b0;
        repeat (3) tick();

        chk("expected_bursts_left", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
